wb_write_arbiter: RTL and testbench

- Writeback stage directly upstream of the 16x16 register file.
- Accepts completed pipeline results (ALU or load data) through a valid/ready handshake and buffers them in a small FIFO.
- Arbitrates them against a priority auxiliary writer (PC/SP/PU updates to R13–R15) onto the register file's single write port (regWrite, A3, WD3).
- Exposes two combinational forwarding lookups so decode can see values still pending in the buffer.

---
 rtl/wb_write_arbiter.sv | 154 +++++++++++++++
 tb/tb_wb_write_arbiter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_write_arbiter.sv
// Writeback arbiter: buffers pipeline results in a small FIFO and muxes them with a priority aux writer onto the register-file write port.
// Optional macro WB_CONFLICT_CNT_EN adds a saturating aux-vs-FIFO conflict counter output (conflict_cnt).
module wb_write_arbiter #(
    parameter int DEPTH = 2,
    parameter int AW    = 4,
    parameter int DW    = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_regWrite,
    input  logic                     in_memToReg,
    input  logic [AW-1:0]            in_rd,
    input  logic [DW-1:0]            in_alu_data,
    input  logic [DW-1:0]            in_mem_data,
    input  logic                     aux_req,
    input  logic [AW-1:0]            aux_rd,
    input  logic [DW-1:0]            aux_wd,
    output logic                     regWrite,
    output logic [AW-1:0]            A3,
    output logic [DW-1:0]            WD3,
    input  logic [AW-1:0]            fwd_addr1,
    input  logic [AW-1:0]            fwd_addr2,
    output logic                     fwd_hit1,
    output logic                     fwd_hit2,
    output logic [DW-1:0]            fwd_data1,
    output logic [DW-1:0]            fwd_data2,
    output logic [$clog2(DEPTH):0]   pending_cnt
`ifdef WB_CONFLICT_CNT_EN
    ,
    output logic [15:0]              conflict_cnt
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] addr_q [DEPTH];
    logic [DW-1:0] data_q [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          aux_act;
    logic          fifo_pop;
    logic          fifo_push;
    logic [DW-1:0] in_data;

    // Aux is masked during reset so the write port is quiet while rst is high.
    assign aux_act   = aux_req & ~rst;
    assign fifo_pop  = ~aux_act & (cnt_q != '0);
    assign in_ready  = ~rst & ((cnt_q < CW'(DEPTH)) | fifo_pop);
    assign fifo_push = in_valid & in_ready & in_regWrite;
    assign in_data   = in_memToReg ? in_mem_data : in_alu_data;
    assign pending_cnt = cnt_q;

    always_comb begin
        regWrite = 1'b0;
        A3       = '0;
        WD3      = '0;
        if (aux_act) begin
            regWrite = 1'b1;
            A3       = aux_rd;
            WD3      = aux_wd;
        end else if (fifo_pop) begin
            regWrite = 1'b1;
            A3       = addr_q[rd_ptr_q];
            WD3      = data_q[rd_ptr_q];
        end
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        if (fifo_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (fifo_push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        case ({fifo_push, fifo_pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Scan oldest to newest so a later match overrides an earlier one.
    logic [PW-1:0] scan_idx;
    always_comb begin
        fwd_hit1  = 1'b0;
        fwd_hit2  = 1'b0;
        fwd_data1 = '0;
        fwd_data2 = '0;
        scan_idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            scan_idx = rd_ptr_q + PW'(i);
            if (CW'(i) < cnt_q) begin
                if (addr_q[scan_idx] == fwd_addr1) begin
                    fwd_hit1  = 1'b1;
                    fwd_data1 = data_q[scan_idx];
                end
                if (addr_q[scan_idx] == fwd_addr2) begin
                    fwd_hit2  = 1'b1;
                    fwd_data2 = data_q[scan_idx];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
            if (fifo_push) begin
                addr_q[wr_ptr_q] <= in_rd;
                data_q[wr_ptr_q] <= in_data;
            end
        end
    end

`ifdef WB_CONFLICT_CNT_EN
    logic [15:0] conflict_q, conflict_d;

    always_comb begin
        conflict_d = conflict_q;
        if (aux_act && (cnt_q != '0) && (conflict_q != 16'hFFFF)) begin
            conflict_d = conflict_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conflict_q <= '0;
        end else begin
            conflict_q <= conflict_d;
        end
    end

    assign conflict_cnt = conflict_q;
`endif

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed bench for wb_write_arbiter: expected FIFO writes are queued at stimulus time and matched against the write port.
// Build with +define+WB_CONFLICT_CNT_EN to also exercise the conflict counter.
module tb_wb_write_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_regWrite, in_memToReg;
    logic [3:0]  in_rd;
    logic [15:0] in_alu_data, in_mem_data;
    logic        aux_req;
    logic [3:0]  aux_rd;
    logic [15:0] aux_wd;
    logic        regWrite;
    logic [3:0]  A3;
    logic [15:0] WD3;
    logic [3:0]  fwd_addr1, fwd_addr2;
    logic        fwd_hit1, fwd_hit2;
    logic [15:0] fwd_data1, fwd_data2;
    logic [1:0]  pending_cnt;
`ifdef WB_CONFLICT_CNT_EN
    logic [15:0] conflict_cnt;
`endif

    int checks = 0;
    int errors = 0;
    logic [19:0] exp_q [$];

    wb_write_arbiter #(.DEPTH(2), .AW(4), .DW(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_regWrite(in_regWrite),
        .in_memToReg(in_memToReg), .in_rd(in_rd),
        .in_alu_data(in_alu_data), .in_mem_data(in_mem_data),
        .aux_req(aux_req), .aux_rd(aux_rd), .aux_wd(aux_wd),
        .regWrite(regWrite), .A3(A3), .WD3(WD3),
        .fwd_addr1(fwd_addr1), .fwd_addr2(fwd_addr2),
        .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
        .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
        .pending_cnt(pending_cnt)
`ifdef WB_CONFLICT_CNT_EN
        , .conflict_cnt(conflict_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic rw, input logic m2r,
                         input logic [3:0] rd, input logic [15:0] alu, input logic [15:0] mem);
        in_valid = v; in_regWrite = rw; in_memToReg = m2r;
        in_rd = rd; in_alu_data = alu; in_mem_data = mem;
    endtask

    // Any FIFO-sourced write must be the oldest outstanding expected entry.
    always @(negedge clk) begin
        if (rst === 1'b0 && regWrite === 1'b1 && aux_req === 1'b0) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", {12'h0, A3, WD3}, 32'hFFFF_FFFF);
            end else begin
                chk("fifo_write", {12'h0, A3, WD3}, {12'h0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        rst = 1'b1;
        drive(1'b0, 1'b1, 1'b0, 4'd0, 16'h0, 16'h0);
        aux_req = 1'b0; aux_rd = 4'd0; aux_wd = 16'h0;
        fwd_addr1 = 4'd0; fwd_addr2 = 4'd0;
        #2;
        chk("rst_regWrite", 32'(regWrite), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        cyc();
        chk("reset_regWrite", 32'(regWrite), 32'd0);
        chk("reset_A3_WD3", {12'h0, A3, WD3}, 32'd0);
        chk("reset_pending", 32'(pending_cnt), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_fwd", {15'h0, fwd_hit1, fwd_data1}, 32'd0);

        // ALU result, written one edge after accept
        drive(1'b1, 1'b1, 1'b0, 4'd3, 16'h00A5, 16'h0000);
        exp_q.push_back({4'd3, 16'h00A5});
        #2 chk("no_bypass", 32'(regWrite), 32'd0);
        cyc();
        drive(1'b0, 1'b1, 1'b0, 4'd0, 16'h0, 16'h0);
        #2 chk("alu_write", {11'h0, regWrite, A3, WD3}, {11'h0, 1'b1, 4'd3, 16'h00A5});
        cyc();
        #2 chk("alu_idle", 32'(regWrite), 32'd0);

        // Load data selection
        drive(1'b1, 1'b1, 1'b1, 4'd7, 16'hFFFF, 16'h1234);
        exp_q.push_back({4'd7, 16'h1234});
        cyc();
        drive(1'b0, 1'b1, 1'b0, 4'd0, 16'h0, 16'h0);
        #2 chk("mem_write", {12'h0, A3, WD3}, {12'h0, 4'd7, 16'h1234});
        cyc();

        // Aux stall: two accepts fill the FIFO, third push back-pressured
        aux_req = 1'b1; aux_rd = 4'd15; aux_wd = 16'h0040;
        drive(1'b1, 1'b1, 1'b0, 4'd1, 16'h0101, 16'h0);
        exp_q.push_back({4'd1, 16'h0101});
        #2 chk("aux_A3_c0", {12'h0, A3, WD3}, {12'h0, 4'd15, 16'h0040});
        cyc();
        drive(1'b1, 1'b1, 1'b0, 4'd2, 16'h0202, 16'h0);
        exp_q.push_back({4'd2, 16'h0202});
        #2 chk("aux_ready_c1", 32'(in_ready), 32'd1);
        cyc();
        drive(1'b1, 1'b1, 1'b0, 4'd3, 16'h0303, 16'h0);
        #2 chk("full_ready_c2", 32'(in_ready), 32'd0);
        chk("full_pending_c2", 32'(pending_cnt), 32'd2);
        chk("aux_A3_c2", 32'(A3), 32'd15);
        cyc();
        #2 chk("full_ready_c3", 32'(in_ready), 32'd0);
        chk("full_pending_c3", 32'(pending_cnt), 32'd2);
        chk("aux_A3_c3", 32'(A3), 32'd15);
        cyc();
        aux_req = 1'b0;
        exp_q.push_back({4'd3, 16'h0303});
        #2 chk("full_pop_ready", 32'(in_ready), 32'd1);
        cyc();
        drive(1'b0, 1'b1, 1'b0, 4'd0, 16'h0, 16'h0);
        #2 chk("full_pushpop_cnt", 32'(pending_cnt), 32'd2);
        cyc();
        cyc();
        #2 chk("drain_idle", {30'h0, regWrite, pending_cnt != 2'd0}, 32'd0);

        // Forwarding: newest match wins
        aux_req = 1'b1; aux_rd = 4'd14; aux_wd = 16'h0055;
        drive(1'b1, 1'b1, 1'b0, 4'd5, 16'h0011, 16'h0);
        exp_q.push_back({4'd5, 16'h0011});
        cyc();
        drive(1'b1, 1'b1, 1'b0, 4'd5, 16'h0022, 16'h0);
        exp_q.push_back({4'd5, 16'h0022});
        cyc();
        drive(1'b0, 1'b1, 1'b0, 4'd0, 16'h0, 16'h0);
        fwd_addr1 = 4'd5; fwd_addr2 = 4'd6;
        #2 chk("fwd1_newest", {15'h0, fwd_hit1, fwd_data1}, {15'h0, 1'b1, 16'h0022});
        chk("fwd2_miss", 32'(fwd_hit2), 32'd0);
        aux_req = 1'b0;
        fwd_addr2 = 4'd5;
        #1 chk("fwd2_newest", {15'h0, fwd_hit2, fwd_data2}, {15'h0, 1'b1, 16'h0022});
        cyc();
        #2 chk("fwd1_popping_head", {15'h0, fwd_hit1, fwd_data1}, {15'h0, 1'b1, 16'h0022});
        cyc();
        #2 chk("fwd1_empty", 32'(fwd_hit1), 32'd0);

        // Discarded result
        drive(1'b1, 1'b0, 1'b0, 4'd9, 16'hBEEF, 16'h0);
        #2 chk("discard_ready", 32'(in_ready), 32'd1);
        cyc();
        drive(1'b0, 1'b1, 1'b0, 4'd0, 16'h0, 16'h0);
        #2 chk("discard_pending", 32'(pending_cnt), 32'd0);
        chk("discard_regWrite", 32'(regWrite), 32'd0);

        // Async reset with a full FIFO and aux active
        aux_req = 1'b1; aux_rd = 4'd13; aux_wd = 16'h0077;
        drive(1'b1, 1'b1, 1'b0, 4'd8, 16'h0888, 16'h0);
        cyc();
        drive(1'b1, 1'b1, 1'b0, 4'd9, 16'h0999, 16'h0);
        cyc();
        drive(1'b0, 1'b1, 1'b0, 4'd0, 16'h0, 16'h0);
        #1 chk("pre_rst_full", 32'(pending_cnt), 32'd2);
        #1 rst = 1'b1;
        #1 chk("rst_async_regWrite", 32'(regWrite), 32'd0);
        chk("rst_async_pending", 32'(pending_cnt), 32'd0);
        aux_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            #2 chk("post_rst_quiet", {30'h0, regWrite, pending_cnt != 2'd0}, 32'd0);
        end

`ifdef WB_CONFLICT_CNT_EN
        chk("conflict_reset", 32'(conflict_cnt), 32'd0);
        aux_req = 1'b1; aux_rd = 4'd15; aux_wd = 16'h0001;
        drive(1'b1, 1'b1, 1'b0, 4'd4, 16'h0444, 16'h0);
        exp_q.push_back({4'd4, 16'h0444});
        cyc();
        drive(1'b0, 1'b1, 1'b0, 4'd0, 16'h0, 16'h0);
        repeat (3) cyc();
        aux_req = 1'b0;
        #2 chk("conflict_three", 32'(conflict_cnt), 32'd3);
        cyc();
        cyc();
        #2 chk("conflict_hold", 32'(conflict_cnt), 32'd3);
`endif

        repeat (3) cyc();
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
